wfg_drive_spi_arbiter: RTL and testbench
========================================

# wfg_drive_spi_arbiter

- Packet-level round-robin arbiter that shares the single AXI-Stream input of `wfg_drive_spi` between `N_REQ` waveform sources.
- Sits between the pattern/stimulus stages and `wfg_drive_spi_top`.
- Grants one requester per packet. Grant is held until the `tlast` beat is accepted.
- Optionally delays the start of each packet to the next `wfg_pat_sync_i` pulse, so SPI frames stay aligned to the pattern timebase.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..4)
- `AXIS_DATA_WIDTH`, 32, tdata width

Ports:
- `wb_clk_i` in 1: system clock, all logic on rising edge
- `wb_rst_i` in 1: reset, asynchronous, active-high
- `wfg_pat_sync_i` in 1: single-cycle pattern sync pulse
- `cfg_en_i` in 1: arbiter enable; new grants only when high
- `cfg_sync_gate_i` in 1: 1 = packet start waits for `wfg_pat_sync_i`
- `req_axis_tvalid_i` in N_REQ: per-requester valid
- `req_axis_tlast_i` in N_REQ: per-requester last
- `req_axis_tdata_i` in N_REQ*AXIS_DATA_WIDTH: requester i in slice [i*W +: W]
- `req_axis_tready_o` out N_REQ: per-requester ready
- `spi_axis_tvalid_o` out 1: to `wfg_drive_spi_axis_tvalid`
- `spi_axis_tlast_o` out 1: to `wfg_drive_spi_axis_tlast`
- `spi_axis_tdata_o` out AXIS_DATA_WIDTH: to `wfg_drive_spi_axis_tdata`
- `spi_axis_tready_i` in 1: from `wfg_drive_spi_axis_tready`
- `grant_o` out N_REQ: one-hot current grant, 0 when none
- `busy_o` out 1: high in WAIT_SYNC or PASS

## Operation
- FSM states: IDLE, WAIT_SYNC, PASS. Reset state is IDLE. Round-robin pointer `rr_ptr` resets to 0.
- IDLE:
  - If `cfg_en_i` and any `req_axis_tvalid_i` bit is set, pick the first set bit scanning upward from `rr_ptr`, wrapping modulo N_REQ.
  - Register the winner into `grant`.
  - Next state is WAIT_SYNC if `cfg_sync_gate_i`, else PASS.
- WAIT_SYNC: hold the grant. On `wfg_pat_sync_i` go to PASS. Outputs stay deasserted.
- PASS: combinational pass-through of the granted requester.
  - `spi_axis_tvalid_o`/`tlast_o`/`tdata_o` are the granted requester's signals.
  - `req_axis_tready_o[g]` = `spi_axis_tready_i`; all other ready bits are 0.
  - On a beat with tvalid & tready & tlast: go to IDLE, clear grant, set `rr_ptr` = (g+1) mod N_REQ.
- Outside PASS:
  - all `req_axis_tready_o` = 0
  - `spi_axis_tvalid_o` = 0, `spi_axis_tlast_o` = 0
  - `spi_axis_tdata_o` = 0
- `cfg_en_i` dropping during WAIT_SYNC or PASS does not abort. The granted packet completes, then the FSM stays in IDLE.
- `cfg_sync_gate_i` is sampled only in IDLE.
- A sync pulse arriving while in IDLE or PASS is ignored; it is not stored.
- Requesters obey AXI-Stream: tvalid is not withdrawn before acceptance. The arbiter does not check this.
- Reset mid-packet: immediately IDLE, all outputs 0, `rr_ptr` = 0. The partial packet is dropped; the SPI driver's own reset covers the downstream side.

## Timing
- Arbitration latency: valid seen in IDLE at cycle N gives grant at N+1. The first beat can transfer at N+1 (ungated).
- Gated: sync pulse at cycle M while in WAIT_SYNC gives PASS at M+1; first beat can transfer at M+1.
- Zero-cycle datapath in PASS; no data registers.
- One mandatory IDLE cycle between consecutive packets: `tlast` accepted at cycle K, earliest next first beat at K+2.
- Single-beat packet (tlast on first beat) is legal: PASS lasts one cycle.
- Reset values: all outputs 0, `busy_o` = 0, `grant_o` = 0.

## Structure
- Package `wfg_drive_spi_arbiter_pkg`:
  - state enum `arb_state_e` {IDLE, WAIT_SYNC, PASS}
  - `MAX_REQ` = 4
- Sub-module `wfg_rr_picker`: combinational rotate/priority-encode/rotate-back. Inputs are the request vector and pointer; outputs are a one-hot winner and a valid flag. Reusable by other shared-resource arbiters.
- Top: FSM, grant/pointer registers, output mux.

## Test plan
1. Ungated, single requester: req0 sends 3 beats 0xA1, 0xA2, 0xA3 (tlast on the 3rd), `tready`=1 -> grant 0 one cycle after valid; beats appear unchanged on `spi_axis_*` in 3 consecutive cycles; then `grant_o` = 0.
2. Both requesters valid continuously, 2-beat packets each, ungated -> grant order 0,1,0,1; one IDLE cycle between packets; req1 tready stays 0 while req0 is granted.
3. Gated: `cfg_sync_gate_i`=1, req1 valid, sync pulse 10 cycles later -> `busy_o`=1 and `spi_axis_tvalid_o`=0 for those cycles; first beat transfers the cycle after the pulse.
4. Backpressure: `spi_axis_tready_i` held 0 for 5 cycles mid-packet -> `spi_axis_tdata_o` stable; granted requester's ready = 0; no beat lost or duplicated.
5. `cfg_en_i` dropped after the first beat of a 4-beat packet -> all 4 beats complete; no new grant while disabled despite valid requests.
6. `wb_rst_i` asserted mid-packet (asynchronous, between clock edges) -> all outputs 0 immediately. After release with both requesters valid, grant goes to req0 (`rr_ptr` = 0).

Source files
------------

// File: rtl/wfg_drive_spi_arbiter_pkg.sv
// Shared types and limits for the wfg_drive_spi packet arbiter.
package wfg_drive_spi_arbiter_pkg;

  localparam int unsigned MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    PASS
  } arb_state_e;

endpackage

// File: rtl/wfg_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module wfg_rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [PW-1:0] idx;

  // Upward scan from ptr is equivalent to rotate / priority-encode / rotate-back.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wfg_drive_spi_arbiter.sv
// Packet-level round-robin arbiter sharing the wfg_drive_spi AXI-Stream input.
module wfg_drive_spi_arbiter
  import wfg_drive_spi_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned AXIS_DATA_WIDTH = 32
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             wfg_pat_sync_i,
  input  logic                             cfg_en_i,
  input  logic                             cfg_sync_gate_i,
  input  logic [N_REQ-1:0]                 req_axis_tvalid_i,
  input  logic [N_REQ-1:0]                 req_axis_tlast_i,
  input  logic [N_REQ*AXIS_DATA_WIDTH-1:0] req_axis_tdata_i,
  output logic [N_REQ-1:0]                 req_axis_tready_o,
  output logic                             spi_axis_tvalid_o,
  output logic                             spi_axis_tlast_o,
  output logic [AXIS_DATA_WIDTH-1:0]       spi_axis_tdata_o,
  input  logic                             spi_axis_tready_i,
  output logic [N_REQ-1:0]                 grant_o,
  output logic                             busy_o
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned W  = AXIS_DATA_WIDTH;

  arb_state_e       state, state_d;
  logic [N_REQ-1:0] grant, grant_d, pick;
  logic [PW-1:0]    rr_ptr, rr_ptr_d, gidx;
  logic             pick_valid, pass;
  logic             sel_valid, sel_last;
  logic [W-1:0]     sel_data;

  wfg_rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .req    (req_axis_tvalid_i),
    .ptr    (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    gidx      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_valid = req_axis_tvalid_i[i];
        sel_last  = req_axis_tlast_i[i];
        sel_data  = req_axis_tdata_i[i*W +: W];
        gidx      = PW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    rr_ptr_d = rr_ptr;
    unique case (state)
      IDLE: begin
        if (cfg_en_i && pick_valid) begin
          grant_d = pick;
          state_d = cfg_sync_gate_i ? WAIT_SYNC : PASS;
        end
      end
      WAIT_SYNC: begin
        if (wfg_pat_sync_i) state_d = PASS;
      end
      PASS: begin
        if (sel_valid && spi_axis_tready_i && sel_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      rr_ptr <= rr_ptr_d;
    end
  end

  assign pass              = (state == PASS);
  assign spi_axis_tvalid_o = pass & sel_valid;
  assign spi_axis_tlast_o  = pass & sel_last;
  assign spi_axis_tdata_o  = pass ? sel_data : '0;
  assign req_axis_tready_o = pass ? (grant & {N_REQ{spi_axis_tready_i}}) : '0;
  assign grant_o           = grant;
  assign busy_o            = (state != IDLE);

endmodule

// File: tb/tb_wfg_drive_spi_arbiter.sv
// Directed bench for wfg_drive_spi_arbiter with a beat scoreboard.
module tb_wfg_drive_spi_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, sync, en, gate, st;
  logic           rv0, rv1, rl0, rl1;
  logic [W-1:0]   rd0, rd1;
  logic [N-1:0]   rv, rl, rr, grant;
  logic [N*W-1:0] rd;
  logic           sv, sl, busy;
  logic [W-1:0]   sd;

  assign rv = {rv1, rv0};
  assign rl = {rl1, rl0};
  assign rd = {rd1, rd0};

  wfg_drive_spi_arbiter #(.N_REQ(N), .AXIS_DATA_WIDTH(W)) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .wfg_pat_sync_i    (sync),
    .cfg_en_i          (en),
    .cfg_sync_gate_i   (gate),
    .req_axis_tvalid_i (rv),
    .req_axis_tlast_i  (rl),
    .req_axis_tdata_i  (rd),
    .req_axis_tready_o (rr),
    .spi_axis_tvalid_o (sv),
    .spi_axis_tlast_o  (sl),
    .spi_axis_tdata_o  (sd),
    .spi_axis_tready_i (st),
    .grant_o           (grant),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [N-1:0] g;
  } exp_t;

  beat_t q0[$], q1[$];
  exp_t  sb[$];
  int    xc[$];
  int    total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push0(input logic [W-1:0] d, input logic l, input bit score);
    beat_t b;
    exp_t  e;
    b.data = d; b.last = l;
    q0.push_back(b);
    if (score) begin
      e.data = d; e.last = l; e.g = 2'b01;
      sb.push_back(e);
    end
  endtask

  task automatic push1(input logic [W-1:0] d, input logic l, input bit score);
    beat_t b;
    exp_t  e;
    b.data = d; b.last = l;
    q1.push_back(b);
    if (score) begin
      e.data = d; e.last = l; e.g = 2'b10;
      sb.push_back(e);
    end
  endtask

  task automatic wait_sb(input int n, input string tag);
    int k;
    k = 0;
    while (sb.size() > n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(sb.size() <= n), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(sv), 64'(0));
    chk({tag, "_tlast"}, 64'(sl), 64'(0));
    chk({tag, "_tdata"}, 64'(sd), 64'(0));
    chk({tag, "_ready"}, 64'(rr), 64'(0));
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Requester 0 driver: present head beat at negedge, retire it when accepted.
  initial begin
    rv0 = 1'b0; rl0 = 1'b0; rd0 = '0;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        rv0 = 1'b1; rl0 = q0[0].last; rd0 = q0[0].data;
      end else begin
        rv0 = 1'b0; rl0 = 1'b0; rd0 = '0;
      end
      #4;
      if (rv0 && rr[0] && q0.size() > 0) void'(q0.pop_front());
    end
  end

  initial begin
    rv1 = 1'b0; rl1 = 1'b0; rd1 = '0;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        rv1 = 1'b1; rl1 = q1[0].last; rd1 = q1[0].data;
      end else begin
        rv1 = 1'b0; rl1 = 1'b0; rd1 = '0;
      end
      #4;
      if (rv1 && rr[1] && q1.size() > 0) void'(q1.pop_front());
    end
  end

  // Output monitor: every accepted beat must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sv && st) begin
        chk("beat_expected", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("beat_data", 64'(sd), 64'(e.data));
          chk("beat_last", 64'(sl), 64'(e.last));
          chk("beat_ready", 64'(rr), 64'(e.g));
          chk("beat_grant", 64'(grant), 64'(e.g));
          xc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m;
    rst = 1'b1; sync = 1'b0; en = 1'b1; gate = 1'b0; st = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // 1: single requester, three beats, ungated
    @(posedge clk); #1;
    xc.delete();
    k = cyc;
    push0(32'hA1, 1'b0, 1'b1);
    push0(32'hA2, 1'b0, 1'b1);
    push0(32'hA3, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_no_early_grant", 64'(grant), 64'(0));
    @(negedge clk);
    chk("t1_grant", 64'(grant), 64'(2'b01));
    chk("t1_busy", 64'(busy), 64'(1));
    wait_sb(0, "t1_drain");
    chk("t1_nbeats", 64'(xc.size()), 64'(3));
    if (xc.size() == 3) begin
      chk("t1_cyc0", 64'(xc[0]), 64'(k + 1));
      chk("t1_cyc1", 64'(xc[1]), 64'(k + 2));
      chk("t1_cyc2", 64'(xc[2]), 64'(k + 3));
    end
    chk("t1_grant_clear", 64'(grant), 64'(0));
    chk("t1_busy_clear", 64'(busy), 64'(0));

    // 2: both requesters contend, expect alternation from pointer 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    xc.delete();
    push0(32'h10, 1'b0, 1'b1); push0(32'h11, 1'b1, 1'b1);
    push1(32'h20, 1'b0, 1'b1); push1(32'h21, 1'b1, 1'b1);
    push0(32'h12, 1'b0, 1'b0); push0(32'h13, 1'b1, 1'b0);
    push1(32'h22, 1'b0, 1'b0); push1(32'h23, 1'b1, 1'b0);
    begin
      exp_t e;
      e.g = 2'b01; e.data = 32'h12; e.last = 1'b0; sb.push_back(e);
      e.data = 32'h13; e.last = 1'b1; sb.push_back(e);
      e.g = 2'b10; e.data = 32'h22; e.last = 1'b0; sb.push_back(e);
      e.data = 32'h23; e.last = 1'b1; sb.push_back(e);
    end
    wait_sb(0, "t2_drain");
    chk("t2_nbeats", 64'(xc.size()), 64'(8));
    if (xc.size() == 8)
      for (int i = 1; i < 8; i++)
        chk("t2_gap", 64'(xc[i] - xc[i-1]), 64'((i % 2) ? 1 : 2));

    // 3: sync-gated start
    @(posedge clk); #1;
    gate = 1'b1;
    xc.delete();
    push1(32'h30, 1'b0, 1'b1);
    push1(32'h31, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("t3_busy", 64'(busy), 64'(1));
      chk("t3_tvalid", 64'(sv), 64'(0));
      chk("t3_ready", 64'(rr), 64'(0));
      chk("t3_grant", 64'(grant), 64'(2'b10));
      @(negedge clk);
    end
    sync = 1'b1;
    gate = 1'b0;
    m = cyc;
    @(negedge clk);
    sync = 1'b0;
    wait_sb(0, "t3_drain");
    chk("t3_nbeats", 64'(xc.size()), 64'(2));
    if (xc.size() > 0) chk("t3_first_after_sync", 64'(xc[0]), 64'(m + 1));

    // 4: backpressure mid-packet
    @(posedge clk); #1;
    push0(32'h40, 1'b0, 1'b1); push0(32'h41, 1'b0, 1'b1);
    push0(32'h42, 1'b0, 1'b1); push0(32'h43, 1'b1, 1'b1);
    wait_sb(2, "t4_two_beats");
    st = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_tdata_stable", 64'(sd), 64'(32'h42));
      chk("t4_tvalid_held", 64'(sv), 64'(1));
      chk("t4_ready_low", 64'(rr), 64'(0));
    end
    st = 1'b1;
    wait_sb(0, "t4_drain");

    // 5: disable after first beat; packet completes, no new grant
    @(posedge clk); #1;
    push0(32'h50, 1'b0, 1'b1); push0(32'h51, 1'b0, 1'b1);
    push0(32'h52, 1'b0, 1'b1); push0(32'h53, 1'b1, 1'b1);
    wait_sb(3, "t5_first_beat");
    en = 1'b0;
    push1(32'h60, 1'b0, 1'b0); push1(32'h61, 1'b1, 1'b0);
    wait_sb(0, "t5_drain");
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_grant", 64'(grant), 64'(0));
      chk("t5_not_busy", 64'(busy), 64'(0));
      chk("t5_no_tvalid", 64'(sv), 64'(0));
    end
    chk("t5_req1_pending", 64'(q1.size()), 64'(2));
    q1.delete();

    // 6: asynchronous reset mid-packet, then arbitration restarts at req0
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    push0(32'h70, 1'b0, 1'b1); push0(32'h71, 1'b0, 1'b1);
    push0(32'h72, 1'b0, 1'b1); push0(32'h73, 1'b1, 1'b1);
    wait_sb(2, "t6_two_beats");
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("t6_reset");
    q0.delete();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    push0(32'h80, 1'b1, 1'b1);
    push1(32'h90, 1'b1, 1'b1);
    wait_sb(0, "t6_drain");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
